seg_disp_arbiter: RTL and testbench
===================================

// Module: seg_disp_arbiter
// PURPOSE
//   Shares the 6-digit BCD seven-segment display among 3 requesters.
//   Fixed priority: 2 > 1 > 0. The current owner is protected by a minimum hold time.
//   Drives the 24-bit BCD input of the display scan driver.
//   Client 0 is the background source (e.g. time of day); clients 1/2 are overlays (setting, alarm).
// PARAMETERS
//   MS_DIV       50000      clk cycles per 1 ms tick (50 MHz clk)
//   HOLD_MS      500        min ms an owner keeps the display before preemption; 0 = no hold
//   DEFAULT_BCD  24'h000000 value shown when nobody owns the display
// PORTS
//   clk        in   1   system clock
//   rst_n      in   1   asynchronous active-low reset
//   req        in   3   per-client request, level; held high while client wants display
//   data0      in   24  client 0 BCD digits, [3:0] = rightmost digit
//   data1      in   24  client 1 BCD digits
//   data2      in   24  client 2 BCD digits
//   grant      out  3   one-hot owner, registered; 3'b000 = idle
//   data_bcd   out  24  registered BCD to the display driver
//   busy       out  1   1 when any grant is active (= |grant)
//   grant_chg  out  1   1-cycle pulse in the cycle grant takes a new value
// BEHAVIOUR
//   Reset (async, any time, including mid-hold): grant=0, data_bcd=DEFAULT_BCD, busy=0,
//     grant_chg=0, state=IDLE, prescaler=0, hold_cnt=0.
//   States:
//     IDLE - no owner
//     HOLD - owner, hold not expired
//     OPEN - owner, hold expired
//   Timing:
//     - req sampled at edge N -> grant and data_bcd take the new value at edge N+1 (1-cycle latency).
//     - While owned, data_bcd <= data[owner] every cycle, so owner data changes show 1 cycle later.
//     - In IDLE, data_bcd <= DEFAULT_BCD.
//   Winner = highest-index asserted req bit.
//   Transitions:
//     IDLE: req!=0 -> grant winner, go to HOLD (OPEN if HOLD_MS==0); pulse grant_chg.
//     HOLD/OPEN, req[owner]==0: release immediately, even inside hold.
//       Other req pending -> grant winner, go to HOLD, pulse grant_chg.
//       No req pending -> IDLE, grant=0, pulse grant_chg.
//     HOLD, higher-priority req: ignored until hold expires.
//       Lower-priority req: always ignored while owner requests.
//     OPEN, higher-priority req: preempt next edge; grant new winner, go to HOLD, pulse grant_chg.
//     Simultaneous owner drop and higher req: owner-drop rule applies; same result, one pulse.
//   Hold timer:
//     - Prescaler 0..MS_DIV-1 emits a 1 ms tick at terminal count.
//     - hold_cnt increments per tick, saturating at HOLD_MS.
//     - Prescaler and hold_cnt clear on every grant change.
//     - HOLD->OPEN at the edge where hold_cnt reaches HOLD_MS.
//     - Hold therefore lasts exactly HOLD_MS*MS_DIV cycles after the grant edge.
//   Widths: prescaler $clog2(MS_DIV), hold_cnt $clog2(HOLD_MS+1); no wrap, since hold_cnt saturates.
//   grant is always one-hot or zero. grant_chg never fires while grant is unchanged.
// TESTING (bench uses MS_DIV=10, HOLD_MS=3 -> hold = 30 cycles)
//   1. Assert and release reset with req=0.
//      -> grant=000, data_bcd=000000, busy=0, grant_chg never pulses.
//   2. req=001, data0=24'h123456.
//      -> next edge: grant=001, data_bcd=123456, grant_chg 1 cycle.
//      Then data0=24'h123457 -> data_bcd follows 1 cycle later.
//   3. Owner 0, raise req[2] 5 cycles after grant.
//      -> grant stays 001 until cycle 30 after grant; then grant=100, data_bcd=data2.
//   4. Owner 2 in HOLD, raise req[1].
//      -> ignored. Then drop req[2] at cycle 4 -> next edge grant=010 (release ignores hold).
//   5. req=111 arrives at once from IDLE.
//      -> grant=100. Drop all req -> grant=000, data_bcd=DEFAULT_BCD, one grant_chg pulse.
//   6. Assert rst_n low mid-HOLD with req[1] still high.
//      -> outputs reset immediately. After release, regrant 010 with a fresh 30-cycle hold.

Source files
------------

// File: rtl/seg_disp_arbiter.sv
// Fixed-priority (2 > 1 > 0) arbiter sharing the 6-digit BCD display among
// three clients, with a minimum hold time protecting the current owner.
module seg_disp_arbiter #(
   parameter int          MS_DIV      = 50000,
   parameter int          HOLD_MS     = 500,
   parameter logic [23:0] DEFAULT_BCD = 24'h000000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [2:0]  req,
   input  logic [23:0] data0,
   input  logic [23:0] data1,
   input  logic [23:0] data2,
   output logic [2:0]  grant,
   output logic [23:0] data_bcd,
   output logic        busy,
   output logic        grant_chg
);

   localparam int PW   = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
   localparam int HC_W = (HOLD_MS > 0) ? $clog2(HOLD_MS + 1) : 1;
   localparam logic [PW-1:0]   PRESC_LAST = PW'(MS_DIV - 1);
   localparam logic [HC_W-1:0] HOLD_LAST  = HC_W'((HOLD_MS > 0) ? HOLD_MS - 1 : 0);
   localparam logic [HC_W-1:0] HOLD_MAX   = HC_W'(HOLD_MS);

   typedef enum logic [1:0] {IDLE, HOLD, OPEN} state_e;

   // A zero hold time means a fresh owner is immediately preemptable.
   localparam state_e START_ST = (HOLD_MS == 0) ? OPEN : HOLD;

   state_e           state_q, state_d;
   logic [2:0]       grant_q, grant_d;
   logic [23:0]      data_bcd_q, data_bcd_d;
   logic             grant_chg_q, grant_chg_d;
   logic [PW-1:0]    presc_q, presc_d;
   logic [HC_W-1:0]  hold_cnt_q, hold_cnt_d;
   logic [2:0]       winner;
   logic             tick;

   always_comb begin
      winner = 3'b000;
      if (req[2])      winner = 3'b100;
      else if (req[1]) winner = 3'b010;
      else if (req[0]) winner = 3'b001;
   end

   assign tick = (presc_q == PRESC_LAST);

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      unique case (state_q)
         IDLE: begin
            if (winner != 3'b000) begin
               grant_d = winner;
               state_d = START_ST;
            end
         end
         HOLD, OPEN: begin
            if ((req & grant_q) == 3'b000) begin
               grant_d = winner;
               state_d = (winner != 3'b000) ? START_ST : IDLE;
            end else if (state_q == OPEN && winner != grant_q) begin
               // Owner still requesting, so any different winner outranks it.
               grant_d = winner;
               state_d = START_ST;
            end else if (state_q == HOLD && tick && hold_cnt_q == HOLD_LAST) begin
               state_d = OPEN;
            end
         end
         default: begin
            grant_d = 3'b000;
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      grant_chg_d = (grant_d != grant_q);
      presc_d     = '0;
      hold_cnt_d  = '0;
      if (!grant_chg_d && state_q != IDLE) begin
         presc_d    = tick ? '0 : presc_q + 1'b1;
         hold_cnt_d = hold_cnt_q;
         if (tick && hold_cnt_q != HOLD_MAX) hold_cnt_d = hold_cnt_q + 1'b1;
      end
   end

   always_comb begin
      unique case (grant_d)
         3'b001:  data_bcd_d = data0;
         3'b010:  data_bcd_d = data1;
         3'b100:  data_bcd_d = data2;
         default: data_bcd_d = DEFAULT_BCD;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         grant_q     <= '0;
         data_bcd_q  <= DEFAULT_BCD;
         grant_chg_q <= 1'b0;
         presc_q     <= '0;
         hold_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         data_bcd_q  <= data_bcd_d;
         grant_chg_q <= grant_chg_d;
         presc_q     <= presc_d;
         hold_cnt_q  <= hold_cnt_d;
      end
   end

   assign grant     = grant_q;
   assign data_bcd  = data_bcd_q;
   assign busy      = |grant_q;
   assign grant_chg = grant_chg_q;

endmodule

// File: tb/tb_seg_disp_arbiter.sv
// Self-checking bench for seg_disp_arbiter: directed scenarios plus random
// request traffic, all checked against an owner/age reference model.
module tb_seg_disp_arbiter;

   localparam int          MS_DIV  = 10;
   localparam int          HOLD_MS = 3;
   localparam logic [23:0] DEF_BCD = 24'h000000;
   localparam int          HOLD_CYC = MS_DIV * HOLD_MS;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  req;
   logic [23:0] data0, data1, data2;
   logic [2:0]  grant;
   logic [23:0] data_bcd;
   logic        busy;
   logic        grant_chg;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: owner index (-1 = none) and edges elapsed since the grant.
   int          m_owner;
   int          m_age;
   logic [23:0] m_data;
   logic        m_chg;

   seg_disp_arbiter #(
      .MS_DIV      (MS_DIV),
      .HOLD_MS     (HOLD_MS),
      .DEFAULT_BCD (DEF_BCD)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .data0     (data0),
      .data1     (data1),
      .data2     (data2),
      .grant     (grant),
      .data_bcd  (data_bcd),
      .busy      (busy),
      .grant_chg (grant_chg)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   function automatic logic [23:0] rand_bcd();
      logic [23:0] v;
      for (int i = 0; i < 6; i++) v[i*4 +: 4] = 4'($urandom_range(0, 9));
      return v;
   endfunction

   function automatic logic [2:0] m_grant();
      return (m_owner < 0) ? 3'b000 : (3'b001 << m_owner);
   endfunction

   task automatic model_reset();
      m_owner = -1;
      m_age   = 0;
      m_data  = DEF_BCD;
      m_chg   = 1'b0;
   endtask

   task automatic model_edge();
      int w;
      int nw;
      if (!rst_n) begin
         model_reset();
         return;
      end
      w = -1;
      for (int i = 0; i < 3; i++) if (req[i]) w = i;
      nw = m_owner;
      if (m_owner < 0)              nw = w;
      else if (!req[m_owner])       nw = w;
      else if (w > m_owner && m_age >= HOLD_CYC) nw = w;
      m_chg = (nw != m_owner);
      if (m_chg) m_age = 0;
      else if (m_age < 100000) m_age++;
      m_owner = nw;
      case (nw)
         0:       m_data = data0;
         1:       m_data = data1;
         2:       m_data = data2;
         default: m_data = DEF_BCD;
      endcase
   endtask

   task automatic check_all();
      check_eq("grant",     32'(grant),     32'(m_grant()));
      check_eq("data_bcd",  32'(data_bcd),  32'(m_data));
      check_eq("busy",      32'(busy),      32'(m_owner >= 0));
      check_eq("grant_chg", 32'(grant_chg), 32'(m_chg));
      check_eq("onehot0",   32'($onehot0(grant)), 32'd1);
   endtask

   // One clock edge: update the model, sample outputs 1 time unit later.
   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      repeat (3) step();
      rst_n = 1'b1;
   endtask

   int k_pre;

   initial begin
      rst_n = 1'b1;
      req   = 3'b000;
      data0 = 24'h000000;
      data1 = 24'h111111;
      data2 = 24'h222222;
      model_reset();
      #2;

      // 1: reset with no requests
      do_reset();
      repeat (5) step();

      // 2: client 0 grant, then data follows
      data0 = 24'h123456;
      req   = 3'b001;
      step();
      check_eq("grant0_first", 32'(grant), 32'h1);
      data0 = 24'h123457;
      step();
      check_eq("data_follow", 32'(data_bcd), 32'h123457);

      // 3: higher request during hold waits for expiry (grant edge was two steps ago)
      k_pre = -1;
      for (int k = 2; k <= 45; k++) begin
         if (k == 5) req = 3'b101;
         step();
         if (k_pre < 0 && grant == 3'b100) k_pre = k;
      end
      check_eq("preempt_lat", 32'(k_pre), 32'(HOLD_CYC + 1));

      // 4: owner 2 in hold; lower request ignored, owner drop releases at once
      req = 3'b000;
      step();
      req = 3'b100;
      step();
      req = 3'b110;
      repeat (3) step();
      check_eq("low_ignored", 32'(grant), 32'h4);
      req = 3'b010;
      step();
      check_eq("release_in_hold", 32'(grant), 32'h2);

      // 5: simultaneous requests from idle, then all drop
      req = 3'b000;
      step();
      req = 3'b111;
      step();
      check_eq("all_req", 32'(grant), 32'h4);
      req = 3'b000;
      step();
      check_eq("drop_all_chg", 32'(grant_chg), 32'h1);
      step();
      check_eq("drop_all_nochg", 32'(grant_chg), 32'h0);

      // 6: asynchronous reset mid-hold, then a fresh hold
      req = 3'b010;
      repeat (10) step();
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      check_eq("async_rst_grant", 32'(grant), 32'h0);
      repeat (2) step();
      rst_n = 1'b1;
      step();
      check_eq("regrant", 32'(grant), 32'h2);
      req = 3'b110;
      repeat (HOLD_CYC + 3) step();
      check_eq("fresh_hold_preempt", 32'(grant), 32'h4);

      // Random traffic with sticky request bits so holds actually expire
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < 3; i++)
            if ($urandom_range(0, 15) == 0) req[i] = ~req[i];
         if ($urandom_range(0, 3) == 0) data0 = rand_bcd();
         if ($urandom_range(0, 3) == 0) data1 = rand_bcd();
         if ($urandom_range(0, 3) == 0) data2 = rand_bcd();
         if ($urandom_range(0, 999) == 0) begin
            #2;
            rst_n = 1'b0;
            #1;
            model_reset();
            check_all();
            step();
            rst_n = 1'b1;
         end
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
